// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 controller-sequencer: opcode values,
// sequencer state encoding, control-word layout and next-state/decode helpers.
package sap1_pkg;

   localparam int unsigned OPC_W  = 4;
   localparam int unsigned TS_W   = 6;
   localparam int unsigned CW_W   = 12;

   localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
   localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
   localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_T6   = 3'd6,
      S_HALT = 3'd7
   } sap1_state_e;

   // Control word, MSB first; *_n fields are active-low strobes.
   typedef struct packed {
      logic pc_inc;
      logic pc_en;
      logic mar_ld_n;
      logic ram_en_n;
      logic ir_ld_n;
      logic ir_en_n;
      logic a_ld_n;
      logic a_en;
      logic alu_sub;
      logic alu_en;
      logic b_ld_n;
      logic out_ld_n;
   } sap1_cw_t;

   localparam sap1_cw_t CW_IDLE = '{
      pc_inc:   1'b0, pc_en:   1'b0, mar_ld_n: 1'b1, ram_en_n: 1'b1,
      ir_ld_n:  1'b1, ir_en_n: 1'b1, a_ld_n:   1'b1, a_en:     1'b0,
      alu_sub:  1'b0, alu_en:  1'b0, b_ld_n:   1'b1, out_ld_n: 1'b1
   };

   // Sequencer transition: T1..T5 free-run, run_i gates IDLE->T1 and T6->T1.
   function automatic sap1_state_e sap1_next_state(input sap1_state_e s,
                                                   input logic run,
                                                   input logic hlt);
      sap1_state_e n;
      case (s)
         S_IDLE:  n = run ? S_T1 : S_IDLE;
         S_T1:    n = S_T2;
         S_T2:    n = S_T3;
         S_T3:    n = S_T4;
         S_T4:    n = hlt ? S_HALT : S_T5;
         S_T5:    n = S_T6;
         S_T6:    n = run ? S_T1 : S_IDLE;
         S_HALT:  n = S_HALT;
         default: n = S_IDLE;
      endcase
      return n;
   endfunction

   // One-hot T-state; zero outside T1..T6.
   function automatic logic [TS_W-1:0] sap1_tstate(input sap1_state_e s);
      logic [TS_W-1:0] t;
      case (s)
         S_T1:    t = 6'b000001;
         S_T2:    t = 6'b000010;
         S_T3:    t = 6'b000100;
         S_T4:    t = 6'b001000;
         S_T5:    t = 6'b010000;
         S_T6:    t = 6'b100000;
         default: t = 6'b000000;
      endcase
      return t;
   endfunction

   function automatic logic sap1_op_defined(input logic [OPC_W-1:0] op);
      return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_OUT) || (op == OP_HLT);
   endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-phase ring counter with IDLE and HALT states.
// Ports: clk_i/rstn_i clock and async active-low reset; i_run continue
// request; i_hlt HLT decoded in T4; o_state current state; o_tstate one-hot
// T1..T6 (0 in IDLE/HALT); o_halt high in HALT.
module sap1_ring_counter
   import sap1_pkg::*;
(
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              i_run,
   input  logic              i_hlt,
   output sap1_state_e       o_state,
   output logic [TS_W-1:0]   o_tstate,
   output logic              o_halt
);

   sap1_state_e      r_state;
   logic [TS_W-1:0]  r_tstate;
   logic             r_halt;

   // tstate/halt are registered from the next state so they track r_state.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state  <= S_IDLE;
         r_tstate <= '0;
         r_halt   <= 1'b0;
      end else begin
         r_state  <= sap1_next_state(r_state, i_run, i_hlt);
         r_tstate <= sap1_tstate(sap1_next_state(r_state, i_run, i_hlt));
         r_halt   <= (sap1_next_state(r_state, i_run, i_hlt) == S_HALT);
      end
   end

   assign o_state  = r_state;
   assign o_tstate = r_tstate;
   assign o_halt   = r_halt;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: ring counter plus microcode decode of the
// opcode into the 12-bit control word.
// Ports: clk_i/rstn_i clock and async active-low reset; run_i keep executing;
// opcode_i IR upper nibble; pc_inc_o..out_ld_n_o control word (*_n_o active
// low); tstate_o one-hot T-state; halt_o in HALT; illegal_o undefined opcode
// in T4.
module sap1_controller
   import sap1_pkg::*;
(
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              run_i,
   input  logic [OPC_W-1:0]  opcode_i,
   output logic              pc_inc_o,
   output logic              pc_en_o,
   output logic              mar_ld_n_o,
   output logic              ram_en_n_o,
   output logic              ir_ld_n_o,
   output logic              ir_en_n_o,
   output logic              a_ld_n_o,
   output logic              a_en_o,
   output logic              alu_sub_o,
   output logic              alu_en_o,
   output logic              b_ld_n_o,
   output logic              out_ld_n_o,
   output logic [TS_W-1:0]   tstate_o,
   output logic              halt_o,
   output logic              illegal_o
);

   sap1_state_e  w_state;
   logic         w_hlt;
   sap1_cw_t     w_cw;
   logic         w_illegal;

   assign w_hlt = (w_state == S_T4) && (opcode_i == OP_HLT);

   sap1_ring_counter u_ring (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .i_run    (run_i),
      .i_hlt    (w_hlt),
      .o_state  (w_state),
      .o_tstate (tstate_o),
      .o_halt   (halt_o)
   );

   // Microcode decode; undefined opcodes and HLT leave T4..T6 inactive.
   always_comb begin
      w_cw      = CW_IDLE;
      w_illegal = 1'b0;
      case (w_state)
         S_T1: begin
            w_cw.pc_en    = 1'b1;
            w_cw.mar_ld_n = 1'b0;
         end
         S_T2: w_cw.pc_inc = 1'b1;
         S_T3: begin
            w_cw.ram_en_n = 1'b0;
            w_cw.ir_ld_n  = 1'b0;
         end
         S_T4: begin
            w_illegal = !sap1_op_defined(opcode_i);
            if (opcode_i == OP_LDA || opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               w_cw.ir_en_n  = 1'b0;
               w_cw.mar_ld_n = 1'b0;
            end else if (opcode_i == OP_OUT) begin
               w_cw.a_en     = 1'b1;
               w_cw.out_ld_n = 1'b0;
            end
         end
         S_T5: begin
            if (opcode_i == OP_LDA) begin
               w_cw.ram_en_n = 1'b0;
               w_cw.a_ld_n   = 1'b0;
            end else if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               w_cw.ram_en_n = 1'b0;
               w_cw.b_ld_n   = 1'b0;
               // Subtract asserted a phase early so the ALU result settles.
               w_cw.alu_sub  = (opcode_i == OP_SUB);
            end
         end
         S_T6: begin
            if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               w_cw.alu_en  = 1'b1;
               w_cw.a_ld_n  = 1'b0;
               w_cw.alu_sub = (opcode_i == OP_SUB);
            end
         end
         default: ;
      endcase
   end

   assign pc_inc_o   = w_cw.pc_inc;
   assign pc_en_o    = w_cw.pc_en;
   assign mar_ld_n_o = w_cw.mar_ld_n;
   assign ram_en_n_o = w_cw.ram_en_n;
   assign ir_ld_n_o  = w_cw.ir_ld_n;
   assign ir_en_n_o  = w_cw.ir_en_n;
   assign a_ld_n_o   = w_cw.a_ld_n;
   assign a_en_o     = w_cw.a_en;
   assign alu_sub_o  = w_cw.alu_sub;
   assign alu_en_o   = w_cw.alu_en;
   assign b_ld_n_o   = w_cw.b_ld_n;
   assign out_ld_n_o = w_cw.out_ld_n;
   assign illegal_o  = w_illegal;

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for sap1_controller with a scoreboard of expected
// {control word, tstate, halt, illegal} vectors.
module tb_sap1_controller;

   localparam int unsigned W = 20;

   // Asserted-signal masks in control-word bit order (MSB = pc_inc).
   localparam logic [11:0] M_PCINC = 12'b1000_0000_0000;
   localparam logic [11:0] M_PCEN  = 12'b0100_0000_0000;
   localparam logic [11:0] M_MARLD = 12'b0010_0000_0000;
   localparam logic [11:0] M_RAMEN = 12'b0001_0000_0000;
   localparam logic [11:0] M_IRLD  = 12'b0000_1000_0000;
   localparam logic [11:0] M_IREN  = 12'b0000_0100_0000;
   localparam logic [11:0] M_ALD   = 12'b0000_0010_0000;
   localparam logic [11:0] M_AEN   = 12'b0000_0001_0000;
   localparam logic [11:0] M_SUB   = 12'b0000_0000_1000;
   localparam logic [11:0] M_ALUEN = 12'b0000_0000_0100;
   localparam logic [11:0] M_BLD   = 12'b0000_0000_0010;
   localparam logic [11:0] M_OUTLD = 12'b0000_0000_0001;
   localparam logic [11:0] LOWMASK = 12'b0011_1110_0011;

   logic       clk_i = 1'b0;
   logic       rstn_i;
   logic       run_i;
   logic [3:0] opcode_i;
   logic       pc_inc_o, pc_en_o, mar_ld_n_o, ram_en_n_o, ir_ld_n_o, ir_en_n_o;
   logic       a_ld_n_o, a_en_o, alu_sub_o, alu_en_o, b_ld_n_o, out_ld_n_o;
   logic [5:0] tstate_o;
   logic       halt_o, illegal_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string        tag;
      logic [W-1:0] val;
   } exp_t;
   exp_t sb_q[$];

   sap1_controller dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .run_i      (run_i),
      .opcode_i   (opcode_i),
      .pc_inc_o   (pc_inc_o),
      .pc_en_o    (pc_en_o),
      .mar_ld_n_o (mar_ld_n_o),
      .ram_en_n_o (ram_en_n_o),
      .ir_ld_n_o  (ir_ld_n_o),
      .ir_en_n_o  (ir_en_n_o),
      .a_ld_n_o   (a_ld_n_o),
      .a_en_o     (a_en_o),
      .alu_sub_o  (alu_sub_o),
      .alu_en_o   (alu_en_o),
      .b_ld_n_o   (b_ld_n_o),
      .out_ld_n_o (out_ld_n_o),
      .tstate_o   (tstate_o),
      .halt_o     (halt_o),
      .illegal_o  (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [W-1:0] observed();
      return {pc_inc_o, pc_en_o, mar_ld_n_o, ram_en_n_o, ir_ld_n_o, ir_en_n_o,
              a_ld_n_o, a_en_o, alu_sub_o, alu_en_o, b_ld_n_o, out_ld_n_o,
              tstate_o, halt_o, illegal_o};
   endfunction

   // Reference microcode: asserted strobes for opcode op in T-state t (1..6).
   function automatic logic [11:0] ref_asserted(input logic [3:0] op, input int t);
      logic [11:0] m;
      m = '0;
      case (t)
         1: m = M_PCEN | M_MARLD;
         2: m = M_PCINC;
         3: m = M_RAMEN | M_IRLD;
         4: if (op == 4'h0 || op == 4'h1 || op == 4'h2) m = M_IREN | M_MARLD;
            else if (op == 4'hE) m = M_AEN | M_OUTLD;
         5: if (op == 4'h0) m = M_RAMEN | M_ALD;
            else if (op == 4'h1) m = M_RAMEN | M_BLD;
            else if (op == 4'h2) m = M_RAMEN | M_BLD | M_SUB;
         6: if (op == 4'h1) m = M_ALUEN | M_ALD;
            else if (op == 4'h2) m = M_ALUEN | M_ALD | M_SUB;
         default: m = '0;
      endcase
      return m;
   endfunction

   function automatic logic [W-1:0] ref_step(input logic [3:0] op, input int t);
      logic [5:0] ts;
      logic       ill;
      ts  = 6'b000001 << (t - 1);
      ill = (t == 4) && !(op == 4'h0 || op == 4'h1 || op == 4'h2 ||
                          op == 4'hE || op == 4'hF);
      return {ref_asserted(op, t) ^ LOWMASK, ts, 1'b0, ill};
   endfunction

   localparam logic [W-1:0] EXP_IDLE = {LOWMASK, 6'b000000, 1'b0, 1'b0};
   localparam logic [W-1:0] EXP_HALT = {LOWMASK, 6'b000000, 1'b1, 1'b0};

   task automatic compare_front();
      exp_t e;
      logic [W-1:0] obs;
      e   = sb_q.pop_front();
      obs = observed();
      checks++;
      assert (obs === e.val) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
      end
   endtask

   // Expectation for the current cycle, compared at the falling edge.
   task automatic chk(input string tag, input logic [W-1:0] v);
      sb_q.push_back('{tag, v});
      @(negedge clk_i);
      compare_front();
   endtask

   // Expectation compared right now (used for asynchronous reset).
   task automatic chk_now(input string tag, input logic [W-1:0] v);
      sb_q.push_back('{tag, v});
      compare_front();
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic run_instr(input string name, input logic [3:0] op, input logic drop_t3);
      opcode_i = op;
      for (int t = 1; t <= 6; t++) begin
         chk($sformatf("%s_T%0d", name, t), ref_step(op, t));
         if (drop_t3 && t == 3) run_i = 1'b0;
         tick();
      end
   endtask

   // At most one bus driver per cycle.
   always @(negedge clk_i) begin
      if (rstn_i === 1'b1) begin
         checks++;
         assert ((int'(pc_en_o) + int'(!ram_en_n_o) + int'(!ir_en_n_o) +
                  int'(a_en_o) + int'(alu_en_o)) <= 1) else begin
            failures++;
            $error("FAIL bus_excl observed pc_en=%b ram_en_n=%b ir_en_n=%b a_en=%b alu_en=%b expected at most one driver",
                   pc_en_o, ram_en_n_o, ir_en_n_o, a_en_o, alu_en_o);
         end
      end
   end

   initial begin
      rstn_i   = 1'b0;
      run_i    = 1'b0;
      opcode_i = 4'h0;
      tick();
      chk_now("reset", EXP_IDLE);
      @(negedge clk_i);
      rstn_i = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         chk($sformatf("idle_%0d", i), EXP_IDLE);
         tick();
      end

      run_i = 1'b1;
      tick();
      run_instr("lda", 4'h0, 1'b0);
      run_instr("sub", 4'h2, 1'b0);
      run_instr("add", 4'h1, 1'b0);
      run_instr("out", 4'hE, 1'b0);
      run_instr("ill", 4'h7, 1'b1);
      chk("idle_after_drop", EXP_IDLE);
      tick();
      chk("idle_hold", EXP_IDLE);

      // Asynchronous reset in the middle of T5.
      run_i    = 1'b1;
      opcode_i = 4'h0;
      tick();
      for (int t = 1; t <= 5; t++) begin
         chk($sformatf("rst5_T%0d", t), ref_step(4'h0, t));
         if (t < 5) tick();
      end
      #1 rstn_i = 1'b0;
      #1 chk_now("rst_mid_t5", EXP_IDLE);
      run_i = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      tick();
      chk("idle_after_rst", EXP_IDLE);

      // HLT then hold in HALT with run_i high.
      run_i    = 1'b1;
      opcode_i = 4'hF;
      tick();
      for (int t = 1; t <= 4; t++) begin
         chk($sformatf("hlt_T%0d", t), ref_step(4'hF, t));
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("halt_%0d", i), EXP_HALT);
         tick();
      end
      #1 rstn_i = 1'b0;
      #1 chk_now("halt_rst", EXP_IDLE);
      run_i = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      tick();
      chk("idle_after_halt", EXP_IDLE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
